// File: rtl/bbox_mem_reader.sv
// ---------------------------------------------------------------------------
// bbox_mem_reader
//   Read-side sequencer for the bounding-box buffer. A start pulse walks
//   memory addresses 0..N-1 and absorbs the memory's one-cycle registered
//   read latency. Each stored {index, data} word is then presented as a
//   valid/ready stream to the NMS compare stage. A 2-entry output FIFO with
//   credit-based read issue gives one word per cycle under continuous
//   m_tready and never drops data under backpressure.
//
// Ports
//   clk        : clock, rising edge
//   gen_rst    : asynchronous active-low reset
//   start      : one-cycle pulse, begin a pass (ignored unless idle)
//   bbox_count : number of entries to read, clamped to memory depth
//   busy       : pass in progress
//   done       : one-cycle pulse when the pass completes
//   raddr      : memory read address
//   mem_ren    : memory read enable (combinational, credit gated)
//   mem_dout   : memory read data, valid the cycle after a mem_ren edge
//   m_tdata    : stream data {index, payload}
//   m_tvalid   : stream valid
//   m_tready   : stream ready
//   m_tlast    : marks the final word of the pass
// ---------------------------------------------------------------------------
module bbox_mem_reader #(
  parameter int BBOX_DATA_WIDTH = 64,
  parameter int BBOX_IND_WIDTH  = 14,
  parameter int MEM_ADDR_WIDTH  = 10,
  localparam int TotalDataWidth = BBOX_IND_WIDTH + BBOX_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      gen_rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH:0]   bbox_count,
  output logic                      busy,
  output logic                      done,
  output logic [MEM_ADDR_WIDTH-1:0] raddr,
  output logic                      mem_ren,
  input  logic [TotalDataWidth-1:0] mem_dout,
  output logic [TotalDataWidth-1:0] m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast
);

  localparam int CntW = MEM_ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] Depth = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                    state_q;
  logic [CntW-1:0]           n_q;
  logic [CntW-1:0]           issued_q;
  logic [CntW-1:0]           wcnt_q;
  logic [MEM_ADDR_WIDTH-1:0] raddr_q;
  logic                      pend_q;
  logic                      done_q;

  logic [1:0]                occ_q;
  logic                      rd_ptr_q;
  logic                      wr_ptr_q;
  logic [1:0]                last_q;
  logic [TotalDataWidth-1:0] data_q [2];

  logic            push;
  logic            pop;
  logic            push_last;
  logic            head_last;
  logic            last_issue;
  logic [2:0]      inflight;
  logic [CntW-1:0] n_clamped;
  logic            mem_ren_d;

  assign n_clamped  = (bbox_count > Depth) ? Depth : bbox_count;
  assign push       = pend_q;
  assign pop        = m_tvalid & m_tready;
  assign push_last  = (wcnt_q == n_q - CntW'(1));
  assign last_issue = (issued_q == n_q - CntW'(1));
  assign head_last  = last_q[rd_ptr_q];

  // Words already committed to the FIFO (buffered or still in the memory
  // pipeline) minus the one leaving this cycle. A pop returns its credit in
  // the same cycle, which is what keeps the stream at one word per cycle.
  assign inflight  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign mem_ren_d = (state_q == FETCH) && (issued_q < n_q) && (inflight < 3'd2);

  assign mem_ren  = mem_ren_d;
  assign raddr    = raddr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign m_tvalid = (occ_q != 2'd0);
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign m_tdata  = m_tvalid ? data_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid & head_last;

  // Sequencer: pass length, issue counter/address, read-pending flag.
  always_ff @(posedge clk or negedge gen_rst) begin
    if (!gen_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      issued_q <= '0;
      raddr_q  <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= mem_ren_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q      <= n_clamped;
            issued_q <= '0;
            raddr_q  <= '0;
            if (n_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (mem_ren_d) begin
            issued_q <= issued_q + CntW'(1);
            raddr_q  <= raddr_q + MEM_ADDR_WIDTH'(1);
            if (last_issue) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output FIFO control: pointers, occupancy, per-entry last flag and the
  // index of the next word to arrive (used to tag the final word).
  always_ff @(posedge clk or negedge gen_rst) begin
    if (!gen_rst) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      last_q   <= 2'b00;
      wcnt_q   <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        wcnt_q <= '0;
      end else if (push) begin
        wcnt_q <= wcnt_q + CntW'(1);
      end
      if (push) begin
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_bbox_mem_reader.sv
module tb_bbox_mem_reader;

  localparam int DW = 64;
  localparam int IW = 14;
  localparam int AW = 10;
  localparam int TW = DW + IW;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          gen_rst;
  logic          start;
  logic [AW:0]   bbox_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic          mem_ren;
  logic [TW-1:0] mem_dout;
  logic [TW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  logic [TW-1:0] mem [D];

  int n_tests = 0;
  int n_fail  = 0;

  bbox_mem_reader #(
    .BBOX_DATA_WIDTH(DW),
    .BBOX_IND_WIDTH (IW),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .gen_rst   (gen_rst),
    .start     (start),
    .bbox_count(bbox_count),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .mem_ren   (mem_ren),
    .mem_dout  (mem_dout),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast)
  );

  always #5 clk = ~clk;

  // One-cycle registered-read memory model
  always @(posedge clk) begin
    if (mem_ren) mem_dout <= mem[raddr];
  end

  function automatic logic [TW-1:0] exp_word(input int i);
    logic [IW-1:0] idx;
    logic [DW-1:0] pay;
    idx = IW'(i);
    pay = 64'hA0 + 64'(i);
    return {idx, pay};
  endfunction

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 3) == 0;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one pass: start with cnt, expect exp_n beats. rmode selects the
  // m_tready pattern; restart_c (>0) re-pulses start in that cycle with a
  // different count, which must be ignored.
  task automatic run_pass(input int cnt, input int exp_n, input int rmode,
                          input int restart_c, input string tag);
    int beats = 0, issues = 0, first_v = -1, done_c = -1, dones = 0;
    int busy_cyc = 0, raddr_bad = 0, credit_bad = 0, stall_bad = 0;
    int budget;
    bit prev_stall = 0;
    logic [TW-1:0] prev_data = '0;
    budget = 4 * exp_n + 30;
    @(posedge clk); #1;
    start = 1'b1; bbox_count = (AW+1)'(cnt); m_tready = rdy(rmode, 0);
    @(negedge clk);
    for (int c = 1; c < budget; c++) begin
      @(posedge clk); #1;
      start      = (c == restart_c);
      bbox_count = (c == restart_c) ? (AW+1)'(2) : (AW+1)'(cnt);
      m_tready   = rdy(rmode, c);
      @(negedge clk);
      if (prev_stall && m_tdata !== prev_data) stall_bad++;
      if (busy) busy_cyc++;
      if (mem_ren) begin
        if (raddr !== AW'(issues % D)) raddr_bad++;
        if (issues - beats - int'(m_tvalid & m_tready) >= 2) credit_bad++;
        issues++;
      end
      if (m_tvalid && first_v < 0) first_v = c;
      if (m_tvalid && m_tready) begin
        chk({tag, "_data"}, 80'(m_tdata), 80'(exp_word(beats)));
        chk({tag, "_tlast"}, 80'(m_tlast), 80'(beats == exp_n - 1));
        beats++;
      end
      if (done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          chk({tag, "_busy_at_done"}, 80'(busy), 80'(0));
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_data  = m_tdata;
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    chk({tag, "_done_seen"}, 80'(done_c >= 0), 80'(1));
    chk({tag, "_done_pulses"}, 80'(dones), 80'(1));
    chk({tag, "_beats"}, 80'(beats), 80'(exp_n));
    chk({tag, "_issues"}, 80'(issues), 80'(exp_n));
    chk({tag, "_raddr_seq_errs"}, 80'(raddr_bad), 80'(0));
    chk({tag, "_credit_errs"}, 80'(credit_bad), 80'(0));
    chk({tag, "_stall_errs"}, 80'(stall_bad), 80'(0));
    if (rmode == 0) begin
      if (exp_n == 0) begin
        chk({tag, "_done_cycle"}, 80'(done_c), 80'(1));
        chk({tag, "_busy_cycles"}, 80'(busy_cyc), 80'(0));
        chk({tag, "_valid_seen"}, 80'(first_v >= 0), 80'(0));
      end else begin
        chk({tag, "_first_valid"}, 80'(first_v), 80'(3));
        chk({tag, "_done_cycle"}, 80'(done_c), 80'(exp_n + 3));
        chk({tag, "_busy_cycles"}, 80'(busy_cyc), 80'(exp_n + 2));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     80'(busy),     80'(0));
    chk({tag, "_done"},     80'(done),     80'(0));
    chk({tag, "_raddr"},    80'(raddr),    80'(0));
    chk({tag, "_mem_ren"},  80'(mem_ren),  80'(0));
    chk({tag, "_tvalid"},   80'(m_tvalid), 80'(0));
    chk({tag, "_tlast"},    80'(m_tlast),  80'(0));
    chk({tag, "_tdata"},    80'(m_tdata),  80'(0));
  endtask

  initial begin
    int beats;
    int stalled;
    for (int i = 0; i < D; i++) mem[i] = exp_word(i);
    gen_rst    = 1'b0;
    start      = 1'b0;
    bbox_count = '0;
    m_tready   = 1'b1;
    mem_dout   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    gen_rst = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(4, 4, 0, -1, "n4");
    run_pass(8, 8, 1, -1, "n8_bp");
    run_pass(0, 0, 0, -1, "n0");
    run_pass(1, 1, 0, -1, "n1");
    run_pass(1024, 1024, 0, -1, "n1024");
    chk("n1024_raddr_wrap", 80'(raddr), 80'(0));
    run_pass(1100, 1024, 0, -1, "n1100");
    chk("n1100_raddr_wrap", 80'(raddr), 80'(0));
    run_pass(8, 8, 0, 2, "restart");
    run_pass(8, 8, 1, 4, "restart_bp");

    // Reset in the middle of a stalled pass with the FIFO full
    beats = 0;
    stalled = 0;
    @(posedge clk); #1;
    start = 1'b1; bbox_count = 11'd10; m_tready = 1'b1;
    @(negedge clk);
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      m_tready = (beats < 6);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        chk("mid_data", 80'(m_tdata), 80'(exp_word(beats)));
        beats++;
      end
      if (!m_tready) stalled++;
      if (stalled >= 4) break;
    end
    chk("mid_beats", 80'(beats), 80'(6));
    chk("mid_full_valid", 80'(m_tvalid), 80'(1));
    chk("mid_full_noren", 80'(mem_ren), 80'(0));
    chk("mid_head_word6", 80'(m_tdata), 80'(exp_word(6)));
    #2 gen_rst = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 chk_all_zero("held_rst");
    #2 gen_rst = 1'b1;
    run_pass(3, 3, 0, -1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bbox_mem_reader.md
# bbox_mem_reader

Read-side sequencer for the bounding-box buffer. On a start pulse it walks read addresses 0..N-1 of the bbox memory, absorbs the memory's one-cycle registered read latency, and presents each stored {index, data} word as a valid/ready stream to the downstream NMS compare stage. A 2-entry output FIFO with credit-based read issue sustains one word per cycle under continuous `m_tready` and never drops data under backpressure.

## Interface
- `BBOX_DATA_WIDTH`, 64, box coordinate/score payload width
- `BBOX_IND_WIDTH`, 14, box index width
- `MEM_ADDR_WIDTH`, 10, memory address width; depth D = 2^MEM_ADDR_WIDTH
- `TotalDataWidth` (localparam), BBOX_IND_WIDTH+BBOX_DATA_WIDTH
- `clk`  in  1  single clock, all logic on rising edge
- `gen_rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse: begin a pass
- `bbox_count`  in  MEM_ADDR_WIDTH+1  entries to read, sampled with `start`
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse: pass complete
- `raddr`  out  MEM_ADDR_WIDTH  memory read address
- `mem_ren`  out  1  memory read enable
- `mem_dout`  in  TotalDataWidth  memory read data, valid the cycle after the `mem_ren` edge
- `m_tdata`  out  TotalDataWidth  stream data
- `m_tvalid`  out  1  stream valid
- `m_tready`  in  1  stream ready
- `m_tlast`  out  1  marks word N-1

## Operation
- States: IDLE, FETCH, DRAIN. `busy` = (state != IDLE).
- IDLE: `start`=1 latches N = min(bbox_count, D) and clears issue counter `raddr` and beat counter. If N=0, stay IDLE and pulse `done` next cycle. Otherwise go to FETCH.
- `start` outside IDLE is ignored.
- FETCH: `mem_ren` is combinational: 1 iff issued<N and (occ + pend − pop) < 2.
  - occ = FIFO occupancy (0..2).
  - pend = registered flag, set on the edge where `mem_ren`=1.
  - pop = `m_tvalid & m_tready`.
- Each issue increments `raddr`, wrapping to 0 after D−1. After issue N−1, go to DRAIN.
- On an edge with pend=1, `mem_dout` is pushed into the FIFO with a tlast bit = (word index == N−1).
- `m_tvalid` = occ>0. `m_tdata`/`m_tlast` = FIFO head. Head is stable while `m_tvalid` & !`m_tready`.
- DRAIN: no issues. On the edge of the final handshake (`m_tlast` beat), go to IDLE and register `done`=1 for one cycle.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- `gen_rst` low at any time: state IDLE, FIFO empty, pend=0, counters 0. `raddr`, `busy`, `done`, `m_tvalid`, `m_tlast` are all 0; `mem_ren` is 0 combinationally. In-flight read data is discarded.
- Reset values: every output is 0.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0. First `mem_ren`/`raddr`=0 during E0–E1. pend=1 after E1. First `m_tvalid` after E2 (2-cycle start-to-data).
- With `m_tready` held 1: one beat per cycle, N beats occupy cycles E2..E2+N−1. `done` high in the cycle after the last beat; `busy` low in that same cycle.
- `m_tready`=0: at most 2 reads beyond the last accepted beat are outstanding or buffered. `mem_ren` stays 0 until a pop frees credit.
- `mem_ren` depends combinationally on `m_tready` (same-cycle credit return).

## Test plan
- **N=4, mem[i]={i,64'hA0+i}, `m_tready`=1:** `mem_ren` high 4 consecutive cycles, `raddr`=0,1,2,3. Beats 0..3 in order on consecutive cycles starting 2 cycles after `start`. `m_tlast` only on beat 3. `done` one cycle later.
- **N=8, `m_tready` toggling 1,0,0,1,…:** all 8 words delivered exactly once, in order. FIFO never exceeds 2. `m_tdata` stable during stalls. `mem_ren` never asserted while occ+pend−pop ≥ 2.
- **N=0:** `done` pulses 1 cycle after `start`. `mem_ren` and `m_tvalid` never assert; `busy` stays 0.
- **N=1024 (D):** `raddr` runs 0..1023 and returns to 0 after the last issue. Exactly 1024 beats. `m_tlast` on beat 1023. `bbox_count`=1100 behaves identically (clamped).
- **`gen_rst` low mid-pass (after beat 5 of 10, `m_tready`=0, FIFO full):** all outputs 0 immediately. After release, a new `start` with N=3 yields beats 0,1,2 with no stale data.
- **`start` pulsed again during FETCH:** ignored, current pass completes with the original N, and exactly one `done` pulse occurs.
